// File: rtl/dfi_lat_pkg.sv
// Shared types and helpers for the DFI latency controller.
// Holds the calibration state encoding and the latency clamp used on rdlat/wrlat.
package dfi_lat_pkg;

    localparam int unsigned MIN_LAT = 2;

    typedef enum logic [2:0] {
        CAL_IDLE,
        CAL_ISSUE,
        CAL_WAIT,
        CAL_DONE,
        CAL_FAIL
    } cal_state_e;

    function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
        if (lat < MIN_LAT) return MIN_LAT;
        if (lat > max_lat) return max_lat;
        return lat;
    endfunction

endpackage

// File: rtl/dfi_lat_ctl_if.sv
// Bundle of DFI strobes, PHY pad controls and calibration signals of dfi_lat_ctl.
// Slave modport is the controller; master modport is whatever drives the DFI side.
interface dfi_lat_ctl_if
    import dfi_lat_pkg::*;
#(
    parameter int NPHASES = 2,
    parameter int MAX_LAT = 15,
    parameter int LATW    = $clog2(MAX_LAT + 2)
) ();

    // Handshake: every strobe here is a single-cycle qualifier sampled on the
    // rising sys_clk edge; there is no ready/back-pressure in either direction.
    logic [LATW-1:0]    rdlat;
    logic [LATW-1:0]    wrlat;
    logic [NPHASES-1:0] dfi_rddata_en;
    logic [NPHASES-1:0] dfi_wrdata_en;
    logic [NPHASES-1:0] dfi_rddata_valid;
    logic               rd_capture_en;
    logic               dq_oe;
    logic               dqs_oe;
    logic               dqs_pre;
    logic               cal_start;
    logic               cal_match;
    logic               cal_rd_req;
    logic               cal_done;
    logic               cal_fail;
    logic [LATW-1:0]    cal_rdlat;
    cal_state_e         cal_state;

    modport slave (
        input  rdlat, wrlat, dfi_rddata_en, dfi_wrdata_en, cal_start, cal_match,
        output dfi_rddata_valid, rd_capture_en, dq_oe, dqs_oe, dqs_pre,
               cal_rd_req, cal_done, cal_fail, cal_rdlat, cal_state
    );

    modport master (
        output rdlat, wrlat, dfi_rddata_en, dfi_wrdata_en, cal_start, cal_match,
        input  dfi_rddata_valid, rd_capture_en, dq_oe, dqs_oe, dqs_pre,
               cal_rd_req, cal_done, cal_fail, cal_rdlat, cal_state
    );

endinterface

// File: rtl/dfi_delay_line.sv
// Shift register exposing every tap; taps[k] is the input as it was k cycles ago.
// taps[0] is the live input, so a register fed from taps[k-1] lands on cycle k.
module dfi_delay_line #(
    parameter int W     = 2,
    parameter int DEPTH = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] taps [DEPTH],
    output logic         busy
);

    logic [W-1:0] stage_q [DEPTH-1];
    logic [W-1:0] stage_d [DEPTH-1];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH - 1; i++) stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH - 1; i++) stage_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) stage_q[i] <= stage_d[i];
        end
    end

    always_comb begin
        taps[0] = din;
        busy    = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            taps[i+1] = stage_q[i];
            busy      = busy | (|stage_q[i]);
        end
    end

endmodule

// File: rtl/dfi_lat_ctl.sv
// DFI read/write latency controller: delays per-phase enables into PHY strobes.
// Read-latency calibration FSM is built only when DFI_LAT_CAL_EN is defined.
module dfi_lat_ctl
    import dfi_lat_pkg::*;
#(
    parameter int NPHASES = 2,
    parameter int MAX_LAT = 15,
    parameter int LATW    = $clog2(MAX_LAT + 2)
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    dfi_lat_ctl_if.slave   bus
);

    localparam int DEPTH = MAX_LAT + 2;
    localparam logic [LATW-1:0] MAX_LAT_L = LATW'(MAX_LAT);

    logic [NPHASES-1:0] rd_taps [DEPTH];
    logic [NPHASES-1:0] wr_taps [DEPTH];
    logic               rd_busy, wr_busy;

    dfi_delay_line #(.W(NPHASES), .DEPTH(DEPTH)) u_rd_line (
        .clk(sys_clk), .rst(sys_rst), .din(bus.dfi_rddata_en), .taps(rd_taps), .busy(rd_busy)
    );

    dfi_delay_line #(.W(NPHASES), .DEPTH(DEPTH)) u_wr_line (
        .clk(sys_clk), .rst(sys_rst), .din(bus.dfi_wrdata_en), .taps(wr_taps), .busy(wr_busy)
    );

    cal_state_e      cal_state;
    logic            cal_valid, cal_rd_req, cal_done, cal_fail, cal_busy_nxt;
    logic [LATW-1:0] cal_rdlat;

`ifdef DFI_LAT_CAL_EN
    cal_state_e      state_q;
    logic [LATW-1:0] cnt_q, cal_rdlat_q;
    logic            cal_valid_q, rd_req_q, done_q, fail_q;

    // cnt_q holds k, the index of the current WAIT cycle (first WAIT cycle is k=1).
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= CAL_IDLE;
            cnt_q       <= '0;
            cal_rdlat_q <= '0;
            cal_valid_q <= 1'b0;
            rd_req_q    <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            rd_req_q <= 1'b0;
            case (state_q)
                CAL_IDLE, CAL_DONE, CAL_FAIL: begin
                    if (bus.cal_start) begin
                        state_q     <= CAL_ISSUE;
                        rd_req_q    <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        cal_valid_q <= 1'b0;
                    end
                end
                CAL_ISSUE: begin
                    cnt_q   <= LATW'(1);
                    state_q <= CAL_WAIT;
                end
                CAL_WAIT: begin
                    if (bus.cal_match) begin
                        cal_rdlat_q <= cnt_q;
                        cal_valid_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= CAL_DONE;
                    end else if (cnt_q == MAX_LAT_L) begin
                        done_q  <= 1'b1;
                        fail_q  <= 1'b1;
                        state_q <= CAL_FAIL;
                    end else begin
                        cnt_q <= cnt_q + LATW'(1);
                    end
                end
                default: state_q <= CAL_IDLE;
            endcase
        end
    end

    // Predicts ISSUE/WAIT for the next cycle so the registered valid is masked on time.
    always_comb begin
        case (state_q)
            CAL_ISSUE: cal_busy_nxt = 1'b1;
            CAL_WAIT:  cal_busy_nxt = !bus.cal_match && (cnt_q != MAX_LAT_L);
            default:   cal_busy_nxt = bus.cal_start;
        endcase
    end

    assign cal_state  = state_q;
    assign cal_valid  = cal_valid_q;
    assign cal_rdlat  = cal_rdlat_q;
    assign cal_rd_req = rd_req_q;
    assign cal_done   = done_q;
    assign cal_fail   = fail_q;
`else
    logic cal_unused;
    assign cal_unused   = bus.cal_start ^ bus.cal_match;
    assign cal_state    = CAL_IDLE;
    assign cal_valid    = 1'b0;
    assign cal_rdlat    = '0;
    assign cal_rd_req   = 1'b0;
    assign cal_done     = 1'b0;
    assign cal_fail     = 1'b0;
    assign cal_busy_nxt = 1'b0;
`endif

    logic [LATW-1:0]    rl_q, rl_d, wl_q, wl_d;
    logic               lat_idle;
    logic [NPHASES-1:0] rd_valid_q, rd_valid_d;
    logic               cap_q, cap_d, dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d, dqs_pre_q, dqs_pre_d;
    logic               wr_pre, wr_dat, wr_post;

    // Latencies only move when nothing is in flight, so a burst keeps its timing.
    always_comb begin
        lat_idle = !rd_busy && !wr_busy && !(|bus.dfi_rddata_en) && !(|bus.dfi_wrdata_en);
        rl_d     = rl_q;
        wl_d     = wl_q;
        if (lat_idle) begin
            rl_d = LATW'(clamp_lat(32'(cal_valid ? cal_rdlat : bus.rdlat), MAX_LAT));
            wl_d = LATW'(clamp_lat(32'(bus.wrlat), MAX_LAT));
        end
    end

    // Each output registers tap (lat-1), which places it exactly lat cycles after the input.
    always_comb begin
        rd_valid_d = cal_busy_nxt ? '0 : rd_taps[rl_q - LATW'(1)];
        cap_d      = |rd_taps[rl_q - LATW'(2)];
        wr_pre     = |wr_taps[wl_q - LATW'(2)];
        wr_dat     = |wr_taps[wl_q - LATW'(1)];
        wr_post    = |wr_taps[wl_q];
        dq_oe_d    = wr_dat;
        dqs_oe_d   = wr_pre | wr_dat | wr_post;
        dqs_pre_d  = wr_pre & ~wr_dat & ~wr_post;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rl_q       <= LATW'(clamp_lat(32'(bus.rdlat), MAX_LAT));
            wl_q       <= LATW'(clamp_lat(32'(bus.wrlat), MAX_LAT));
            rd_valid_q <= '0;
            cap_q      <= 1'b0;
            dq_oe_q    <= 1'b0;
            dqs_oe_q   <= 1'b0;
            dqs_pre_q  <= 1'b0;
        end else begin
            rl_q       <= rl_d;
            wl_q       <= wl_d;
            rd_valid_q <= rd_valid_d;
            cap_q      <= cap_d;
            dq_oe_q    <= dq_oe_d;
            dqs_oe_q   <= dqs_oe_d;
            dqs_pre_q  <= dqs_pre_d;
        end
    end

    assign bus.dfi_rddata_valid = rd_valid_q;
    assign bus.rd_capture_en    = cap_q;
    assign bus.dq_oe            = dq_oe_q;
    assign bus.dqs_oe           = dqs_oe_q;
    assign bus.dqs_pre          = dqs_pre_q;
    assign bus.cal_rd_req       = cal_rd_req;
    assign bus.cal_done         = cal_done;
    assign bus.cal_fail         = cal_fail;
    assign bus.cal_rdlat        = cal_rdlat;
    assign bus.cal_state        = cal_state;

endmodule

// File: tb/tb_dfi_lat_ctl.sv
// Bench for dfi_lat_ctl: every cycle is compared against an event-based timing model.
// Calibration scenarios run when DFI_LAT_CAL_EN is defined, the tie-off scenario otherwise.
module tb_dfi_lat_ctl;
    import dfi_lat_pkg::*;

    localparam int NP = 2;
    localparam int ML = 15;
    localparam int HN = 2048;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    dfi_lat_ctl_if #(.NPHASES(NP), .MAX_LAT(ML)) bus ();

    dfi_lat_ctl #(.NPHASES(NP), .MAX_LAT(ML)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 10;

    // Expected events indexed by absolute cycle number.
    logic [NP-1:0] rd_exp  [HN];
    logic          cap_exp [HN];
    logic          dat_exp [HN];
    int            rl_m, wl_m, last_en, cal_lat_m;
    logic          cal_valid_m, cal_busy_m;
    logic          exp_rd_req, exp_done, exp_fail;
    int            exp_cal_rdlat;

    function automatic int clamp_m(input int v);
        return (v < 2) ? 2 : ((v > ML) ? ML : v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // A burst issued in cycle t uses the latency in force at t; latencies only
    // change once no enable has been seen for ML+1 cycles and none is present.
    task automatic model_update();
        logic rd_any, wr_any;
        rd_any = |bus.dfi_rddata_en;
        wr_any = |bus.dfi_wrdata_en;
        if (sys_rst) begin
            for (int i = 0; i < HN; i++) begin
                rd_exp[i]  = '0;
                cap_exp[i] = 1'b0;
                dat_exp[i] = 1'b0;
            end
            last_en     = -1000;
            rl_m        = clamp_m(int'(bus.rdlat));
            wl_m        = clamp_m(int'(bus.wrlat));
            cal_valid_m = 1'b0;
            cal_lat_m   = 0;
        end else begin
            if (rd_any) begin
                rd_exp[cyc + rl_m]      = rd_exp[cyc + rl_m] | bus.dfi_rddata_en;
                cap_exp[cyc + rl_m - 1] = 1'b1;
            end
            if (wr_any) dat_exp[cyc + wl_m] = 1'b1;
            if (!rd_any && !wr_any && (cyc - last_en > ML + 1)) begin
                rl_m = clamp_m(cal_valid_m ? cal_lat_m : int'(bus.rdlat));
                wl_m = clamp_m(int'(bus.wrlat));
            end
            if (rd_any || wr_any) last_en = cyc;
        end
    endtask

    task automatic check_cycle();
        chk("rddata_valid", 32'(bus.dfi_rddata_valid), cal_busy_m ? 32'd0 : 32'(rd_exp[cyc]));
        chk("rd_capture_en", 32'(bus.rd_capture_en), 32'(cap_exp[cyc]));
        chk("dq_oe", 32'(bus.dq_oe), 32'(dat_exp[cyc]));
        chk("dqs_oe", 32'(bus.dqs_oe), 32'(dat_exp[cyc-1] | dat_exp[cyc] | dat_exp[cyc+1]));
        chk("dqs_pre", 32'(bus.dqs_pre), 32'(dat_exp[cyc+1] & ~dat_exp[cyc] & ~dat_exp[cyc-1]));
        chk("cal_rd_req", 32'(bus.cal_rd_req), 32'(exp_rd_req));
        chk("cal_done", 32'(bus.cal_done), 32'(exp_done));
        chk("cal_fail", 32'(bus.cal_fail), 32'(exp_fail));
        chk("cal_rdlat", 32'(bus.cal_rdlat), 32'(exp_cal_rdlat));
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_update();
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_en();
        bus.dfi_rddata_en = '0;
        bus.dfi_wrdata_en = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst       = 1'b1;
        bus.rdlat     = 5;
        bus.wrlat     = 3;
        bus.cal_start = 1'b0;
        bus.cal_match = 1'b0;
        clear_en();
        cal_busy_m    = 1'b0;
        cal_valid_m   = 1'b0;
        cal_lat_m     = 0;
        exp_rd_req    = 1'b0;
        exp_done      = 1'b0;
        exp_fail      = 1'b0;
        exp_cal_rdlat = 0;

        // reset state
        idle(3);
        sys_rst = 1'b0;
        idle(20);

        // read path: rdlat=5, phase-1 read
        bus.dfi_rddata_en = 2'b10;
        step();
        clear_en();
        idle(20);

        // write path: wrlat=3, back-to-back full-phase writes
        bus.dfi_wrdata_en = 2'b11;
        idle(2);
        clear_en();
        idle(20);

        // writes with a one-cycle gap: second preamble must be suppressed
        bus.wrlat = 4;
        idle(20);
        bus.dfi_wrdata_en = 2'b01;
        step();
        clear_en();
        step();
        bus.dfi_wrdata_en = 2'b10;
        step();
        clear_en();
        idle(20);

        // clamp low
        bus.rdlat = 0;
        bus.wrlat = 1;
        idle(20);
        bus.dfi_rddata_en = 2'b01;
        bus.dfi_wrdata_en = 2'b01;
        step();
        clear_en();
        idle(20);

        // clamp high
        bus.rdlat = 20;
        bus.wrlat = 25;
        idle(20);
        bus.dfi_rddata_en = 2'b11;
        bus.dfi_wrdata_en = 2'b10;
        step();
        clear_en();
        idle(20);

        // latency change while a read is in flight
        bus.rdlat = 4;
        idle(20);
        bus.dfi_rddata_en = 2'b01;
        step();
        clear_en();
        bus.rdlat = 7;
        idle(20);
        bus.dfi_rddata_en = 2'b01;
        step();
        clear_en();
        idle(20);

        // randomized traffic with occasional latency changes
        for (int i = 0; i < 400; i++) begin
            bus.dfi_rddata_en = ($urandom_range(0, 3) == 0) ? NP'($urandom_range(1, 3)) : '0;
            bus.dfi_wrdata_en = ($urandom_range(0, 3) == 0) ? NP'($urandom_range(1, 3)) : '0;
            if ($urandom_range(0, 15) == 0) bus.rdlat = 5'($urandom_range(0, 20));
            if ($urandom_range(0, 15) == 0) bus.wrlat = 5'($urandom_range(0, 20));
            step();
        end
        clear_en();
        idle(20);

        // reset mid-burst
        bus.rdlat = 6;
        bus.wrlat = 5;
        idle(20);
        bus.dfi_rddata_en = 2'b11;
        bus.dfi_wrdata_en = 2'b11;
        idle(2);
        clear_en();
        step();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        idle(20);

`ifdef DFI_LAT_CAL_EN
        // calibration pass; a read issued with cal_start lands inside WAIT and is masked
        bus.rdlat = 2;
        idle(20);
        bus.cal_start     = 1'b1;
        bus.dfi_rddata_en = 2'b01;
        cal_busy_m        = 1'b1;
        exp_rd_req        = 1'b1;
        step();
        bus.cal_start = 1'b0;
        clear_en();
        bus.cal_match = 1'b1;
        exp_rd_req    = 1'b0;
        step();
        bus.cal_match = 1'b0;
        idle(5);
        bus.cal_match = 1'b1;
        cal_busy_m    = 1'b0;
        exp_done      = 1'b1;
        exp_cal_rdlat = 6;
        step();
        bus.cal_match = 1'b0;
        cal_valid_m   = 1'b1;
        cal_lat_m     = 6;
        bus.rdlat     = 9;
        idle(20);
        bus.dfi_rddata_en = 2'b10;
        step();
        clear_en();
        idle(20);

        // calibration fail: no match for ML wait cycles; cal_start during WAIT ignored
        bus.cal_start = 1'b1;
        cal_busy_m    = 1'b1;
        exp_rd_req    = 1'b1;
        exp_done      = 1'b0;
        step();
        bus.cal_start = 1'b0;
        exp_rd_req    = 1'b0;
        cal_valid_m   = 1'b0;
        step();
        bus.cal_start = 1'b1;
        step();
        bus.cal_start = 1'b0;
        idle(13);
        cal_busy_m = 1'b0;
        exp_done   = 1'b1;
        exp_fail   = 1'b1;
        step();
        idle(20);
        bus.dfi_rddata_en = 2'b01;
        step();
        clear_en();
        idle(20);

        // restart clears the flags; reset during WAIT returns everything to zero
        bus.cal_start = 1'b1;
        cal_busy_m    = 1'b1;
        exp_rd_req    = 1'b1;
        exp_done      = 1'b0;
        exp_fail      = 1'b0;
        step();
        bus.cal_start = 1'b0;
        exp_rd_req    = 1'b0;
        idle(3);
        sys_rst       = 1'b1;
        cal_busy_m    = 1'b0;
        exp_cal_rdlat = 0;
        step();
        sys_rst = 1'b0;
        idle(20);
        bus.dfi_rddata_en = 2'b11;
        step();
        clear_en();
        idle(20);
`else
        // calibration disabled: strobes ignored, reads follow rdlat unmasked
        bus.rdlat = 3;
        idle(20);
        bus.cal_start     = 1'b1;
        bus.dfi_rddata_en = 2'b01;
        step();
        bus.cal_start     = 1'b0;
        clear_en();
        bus.cal_match     = 1'b1;
        idle(3);
        bus.cal_match = 1'b0;
        idle(20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dfi_lat_ctl.md
# dfi_lat_ctl

Parametrised DFI latency controller for the multi-phase DDR PHYs, generalising the fixed two-phase read/write timing to NPHASES phases with runtime-programmable read and write latency. It sits between the DFI phase bundles and the pad SERDES. It delays the per-phase rddata_en and wrdata_en strobes to produce dfi_rddata_valid, input-capture enable and DQ/DQS output-enable with preamble and postamble. Optionally, a calibration FSM measures read latency in-system.

## Interface
- NPHASES, 2, number of DFI phases per sys_clk cycle
- MAX_LAT, 15, largest supported latency in sys_clk cycles (≥2)
- LATW, $clog2(MAX_LAT+2), latency field width
- sys_clk  in  1  single clock; all logic rising-edge
- sys_rst  in  1  reset, synchronous, active-high
- rdlat  in  LATW  read latency: rddata_en → rddata_valid, in cycles
- wrlat  in  LATW  write latency: wrdata_en → DQ driven, in cycles
- dfi_rddata_en  in  NPHASES  per-phase read enable
- dfi_wrdata_en  in  NPHASES  per-phase write enable
- dfi_rddata_valid  out  NPHASES  per-phase read data valid
- rd_capture_en  out  1  input SERDES capture enable
- dq_oe  out  1  drive DQ/DM
- dqs_oe  out  1  drive DQS, including preamble and postamble
- dqs_pre  out  1  preamble cycle; DQS held low
- cal_start  in  1  start read-latency calibration (pulse)
- cal_match  in  1  comparator: captured word equals the calibration pattern
- cal_rd_req  out  1  one-cycle request to the controller mux to issue a phase-0 read
- cal_done  out  1  calibration finished
- cal_fail  out  1  calibration found no match
- cal_rdlat  out  LATW  measured latency

## Operation
- Two tapped delay lines, each depth MAX_LAT+2 and NPHASES bits wide: rd line fed by dfi_rddata_en, wr line fed by dfi_wrdata_en. Tap k means k cycles after input sampling.
- Effective latencies are clamped to the range [2, MAX_LAT]: rl_eff for read, wl_eff for write.
- rl_eff = cal_rdlat when calibration is valid, else rdlat.
- Latency update: internal copies of rdlat and wrlat load only in a cycle where both delay lines are all-zero and no enable input is asserted. Otherwise the previous value is held, so in-flight bursts keep their original timing.
- dfi_rddata_valid = rd tap[rl_eff], per phase.
- rd_capture_en = OR over phases of rd tap[rl_eff-1].
- dq_oe = OR over phases of wr tap[wl_eff].
- dqs_oe = OR of wr taps wl_eff-1, wl_eff and wl_eff+1.
- dqs_pre = wr tap[wl_eff-1] & ~wr tap[wl_eff]; asserted only when the previous cycle was not a write data cycle.
- Back-to-back writes: dq_oe is continuous; there is no intermediate pre/postamble.
- Calibration FSM states: IDLE, ISSUE, WAIT, DONE, FAIL.
  - IDLE → ISSUE on cal_start. cal_start is ignored in ISSUE and WAIT.
  - ISSUE: cal_rd_req=1 for one cycle; cnt←0; → WAIT.
  - WAIT: cnt increments each cycle, giving cycle k≥1 after ISSUE. On cal_match: cal_rdlat←k, → DONE. If k reaches MAX_LAT with no match: → FAIL.
  - A cal_match asserted during the ISSUE cycle is ignored.
  - DONE: cal_done=1 and calibration becomes valid.
  - FAIL: cal_done=1, cal_fail=1, calibration invalid.
  - From DONE or FAIL, cal_start → ISSUE, which clears cal_done, cal_fail and the valid flag.
- During ISSUE and WAIT, dfi_rddata_valid is forced to 0.

## Timing
- Reset: both delay lines cleared and all outputs 0.
  - cal_rdlat=0, valid flag cleared, FSM in IDLE.
  - Latency copies load from rdlat/wrlat on the first cycle after reset.
- Reset mid-burst aborts the burst; outputs are 0 in the following cycle.
- rddata_en in cycle t → dfi_rddata_valid in cycle t+rl_eff, with the same phase bits.
- wrdata_en in cycle t:
  - dqs_oe and dqs_pre in cycle t+wl_eff-1;
  - dq_oe in cycle t+wl_eff;
  - dqs_oe stays high through cycle t+wl_eff+1.
- Out-of-range values are clamped: 0 or 1 → 2; >MAX_LAT → MAX_LAT.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- DFI_LAT_CAL_EN defined: calibration FSM present as described above.
- DFI_LAT_CAL_EN undefined:
  - Ports remain; cal_start and cal_match are ignored.
  - cal_rd_req, cal_done, cal_fail and cal_rdlat are tied to 0.
  - rl_eff is always taken from rdlat.

## Structure
- Package dfi_lat_pkg:
  - calibration state enum;
  - constant MIN_LAT=2;
  - clamp function for latency values.
- Sub-module dfi_delay_line: parametrised width/depth shift register exposing all taps. It is instantiated twice, once for the rd line and once for the wr line.

## Test plan
- Read path: NPHASES=2, rdlat=5, rddata_en=2'b10 at cycle 10 → rd_capture_en at 14; dfi_rddata_valid=2'b10 at 15 only.
- Write path with preamble: wrlat=3, wrdata_en=2'b11 at cycles 20 and 21 → dqs_pre at 22; dq_oe at 23–24; dqs_oe at 22–25; no second preamble.
- Clamping and latency update: rdlat=0 → valid 2 cycles later. Change rdlat 4→7 while a read is in flight → that read completes at 4; the next read after the pipe drains uses 7.
- Calibration pass: cal_start, then cal_match 6 cycles after cal_rd_req → cal_done=1, cal_rdlat=6, subsequent reads valid at +6 regardless of the rdlat input.
- Calibration fail/restart: MAX_LAT=15, no cal_match → FAIL with cal_fail=1 after 15 WAIT cycles. A new cal_start clears the flags. sys_rst during WAIT → IDLE with all outputs 0.
- Macro off: build without DFI_LAT_CAL_EN; cal_start pulse → cal_rd_req and cal_done stay 0; read timing follows rdlat.
